// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage: NOP encoding,
// instruction width, default reset vector and the fetch state encoding.
package instruction_fetch_pkg;

    localparam int          INSTR_WIDTH          = 32;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter for the fetch stage: holds, advances by 4, or loads a
// word-aligned redirect target. Wraps modulo 2^32.
module program_counter
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            // Low two bits dropped so the PC can never leave word alignment.
            pc_d = target & 32'hFFFF_FFFC;
        end else if (advance) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, ROM addressing and the IF/ID register with stall/redirect.
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
    parameter int          ROM_ADDR_WIDTH = 10
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      STALL,
    input  logic                      BRANCH_TAKEN,
    input  logic [31:0]               BRANCH_TARGET,
    output logic [ROM_ADDR_WIDTH-1:0] ROM_ADDRESS,
    input  logic [INSTR_WIDTH-1:0]    ROM_DATA,
    output logic [INSTR_WIDTH-1:0]    IFID_INSTRUCTION,
    output logic [31:0]               IFID_PC,
    output logic                      IFID_VALID,
    output logic                      FETCH_FAULT
);

    logic [31:0]            pc;
    logic                   pc_load;
    logic                   pc_advance;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [31:0]            ifid_pc_q, ifid_pc_d;
    logic                   valid_q, valid_d;
    logic                   misaligned;
    fetch_state_e           state_q;

    program_counter #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc (
        .clk    (CLK),
        .rst    (RESET),
        .load   (pc_load),
        .advance(pc_advance),
        .target (BRANCH_TARGET),
        .pc     (pc)
    );

    assign ROM_ADDRESS = pc[ROM_ADDR_WIDTH+1:2];

`ifdef FETCH_MISALIGN_CHECK_EN
    fetch_state_e state_d;

    assign misaligned = BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (misaligned) state_d = FAULT;
            FAULT:   state_d = FAULT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        FETCH_FAULT = (state_q == FAULT);
    end
`else
    assign misaligned  = 1'b0;
    assign state_q     = RUN;
    assign FETCH_FAULT = 1'b0;
`endif

    always_comb begin
        instr_d    = instr_q;
        ifid_pc_d  = ifid_pc_q;
        valid_d    = valid_q;
        pc_load    = 1'b0;
        pc_advance = 1'b0;
        if (state_q == FAULT || BRANCH_TAKEN) begin
            instr_d   = NOP_INSTR;
            ifid_pc_d = 32'd0;
            valid_d   = 1'b0;
            // A misaligned redirect leaves the PC where it was.
            pc_load   = (state_q == RUN) && !misaligned;
        end else if (!STALL) begin
            instr_d    = ROM_DATA;
            ifid_pc_d  = pc;
            valid_d    = 1'b1;
            pc_advance = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            instr_q   <= NOP_INSTR;
            ifid_pc_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            ifid_pc_q <= ifid_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign IFID_INSTRUCTION = instr_q;
    assign IFID_PC          = ifid_pc_q;
    assign IFID_VALID       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, redirect,
// PC wrap, misaligned redirect (either build) and asynchronous reset.
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [9:0]  ROM_ADDRESS;
    logic [31:0] ROM_DATA;
    logic [31:0] IFID_INSTRUCTION;
    logic [31:0] IFID_PC;
    logic        IFID_VALID;
    logic        FETCH_FAULT;

    logic [31:0] rom [0:1023];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 CLK = ~CLK;

    assign ROM_DATA = rom[ROM_ADDRESS];

    instruction_fetch dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .STALL           (STALL),
        .BRANCH_TAKEN    (BRANCH_TAKEN),
        .BRANCH_TARGET   (BRANCH_TARGET),
        .ROM_ADDRESS     (ROM_ADDRESS),
        .ROM_DATA        (ROM_DATA),
        .IFID_INSTRUCTION(IFID_INSTRUCTION),
        .IFID_PC         (IFID_PC),
        .IFID_VALID      (IFID_VALID),
        .FETCH_FAULT     (FETCH_FAULT)
    );

    // Advance one rising edge and sample 1 ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
        cycle++;
        $display("cycle %0d: ifid_pc=%08h instr=%08h valid=%0b fault=%0b rom_addr=%03h",
                 cycle, IFID_PC, IFID_INSTRUCTION, IFID_VALID, FETCH_FAULT, ROM_ADDRESS);
    endtask

    task automatic test_reset();
        RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'd0;
        repeat (2) @(negedge CLK);
        checks++;
        if (IFID_INSTRUCTION !== 32'h0000_0013 || IFID_PC !== 32'd0 || IFID_VALID !== 1'b0
            || FETCH_FAULT !== 1'b0 || ROM_ADDRESS !== 10'd0) begin
            errors++;
            $display("FAIL reset_values: instr=%08h pc=%08h valid=%0b fault=%0b addr=%03h, need 00000013/0/0/0/000",
                     IFID_INSTRUCTION, IFID_PC, IFID_VALID, FETCH_FAULT, ROM_ADDRESS);
        end
        RESET = 1'b0;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (IFID_PC !== 32'(4 * k) || IFID_INSTRUCTION !== rom[k] || IFID_VALID !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch_%0d: pc=%08h instr=%08h valid=%0b, need %08h/%08h/1",
                         k, IFID_PC, IFID_INSTRUCTION, IFID_VALID, 4 * k, rom[k]);
            end
        end
    endtask

    task automatic test_stall();
        STALL = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (IFID_PC !== 32'd8 || IFID_INSTRUCTION !== rom[2] || IFID_VALID !== 1'b1
                || ROM_ADDRESS !== 10'd3) begin
                errors++;
                $display("FAIL stall_hold_%0d: pc=%08h instr=%08h valid=%0b addr=%03h, need 00000008/%08h/1/003",
                         k, IFID_PC, IFID_INSTRUCTION, IFID_VALID, ROM_ADDRESS, rom[2]);
            end
        end
        STALL = 1'b0;
        tick();
        checks++;
        if (IFID_PC !== 32'd12 || IFID_INSTRUCTION !== rom[3] || IFID_VALID !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: pc=%08h instr=%08h valid=%0b, need 0000000c/%08h/1",
                     IFID_PC, IFID_INSTRUCTION, IFID_VALID, rom[3]);
        end
    endtask

    task automatic test_branch_over_stall();
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h20; STALL = 1'b1;
        tick();
        BRANCH_TAKEN = 1'b0; STALL = 1'b0;
        checks++;
        if (IFID_VALID !== 1'b0 || IFID_INSTRUCTION !== 32'h0000_0013 || IFID_PC !== 32'd0
            || ROM_ADDRESS !== 10'd8) begin
            errors++;
            $display("FAIL branch_bubble: valid=%0b instr=%08h pc=%08h addr=%03h, need 0/00000013/0/008",
                     IFID_VALID, IFID_INSTRUCTION, IFID_PC, ROM_ADDRESS);
        end
        tick();
        checks++;
        if (IFID_PC !== 32'h20 || IFID_INSTRUCTION !== rom[8] || IFID_VALID !== 1'b1) begin
            errors++;
            $display("FAIL branch_target: pc=%08h instr=%08h valid=%0b, need 00000020/%08h/1",
                     IFID_PC, IFID_INSTRUCTION, IFID_VALID, rom[8]);
        end
    endtask

    task automatic test_wrap();
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
        tick();
        BRANCH_TAKEN = 1'b0;
        checks++;
        if (ROM_ADDRESS !== 10'h3FF || IFID_VALID !== 1'b0) begin
            errors++;
            $display("FAIL wrap_addr: addr=%03h valid=%0b, need 3ff/0", ROM_ADDRESS, IFID_VALID);
        end
        tick();
        checks++;
        if (IFID_PC !== 32'hFFFF_FFFC || IFID_INSTRUCTION !== rom[1023] || ROM_ADDRESS !== 10'd0) begin
            errors++;
            $display("FAIL wrap_fetch: pc=%08h instr=%08h addr=%03h, need fffffffc/%08h/000",
                     IFID_PC, IFID_INSTRUCTION, ROM_ADDRESS, rom[1023]);
        end
        tick();
        checks++;
        if (IFID_PC !== 32'd0 || IFID_INSTRUCTION !== rom[0] || IFID_VALID !== 1'b1) begin
            errors++;
            $display("FAIL wrap_zero: pc=%08h instr=%08h valid=%0b, need 00000000/%08h/1",
                     IFID_PC, IFID_INSTRUCTION, IFID_VALID, rom[0]);
        end
    endtask

    task automatic test_misalign();
        // PC is 4 on entry (ROM_ADDRESS 1).
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h22;
        tick();
        BRANCH_TAKEN = 1'b0;
        checks++;
        if (IFID_VALID !== 1'b0 || IFID_INSTRUCTION !== 32'h0000_0013) begin
            errors++;
            $display("FAIL misalign_bubble: valid=%0b instr=%08h, need 0/00000013",
                     IFID_VALID, IFID_INSTRUCTION);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++;
        if (FETCH_FAULT !== 1'b1 || ROM_ADDRESS !== 10'd1) begin
            errors++;
            $display("FAIL misalign_fault: fault=%0b addr=%03h, need 1/001", FETCH_FAULT, ROM_ADDRESS);
        end
        for (int k = 0; k < 3; k++) begin
            BRANCH_TAKEN = (k == 1); BRANCH_TARGET = 32'h40; STALL = (k == 2);
            tick();
            checks++;
            if (FETCH_FAULT !== 1'b1 || IFID_VALID !== 1'b0 || IFID_INSTRUCTION !== 32'h0000_0013
                || IFID_PC !== 32'd0 || ROM_ADDRESS !== 10'd1) begin
                errors++;
                $display("FAIL fault_sticky_%0d: fault=%0b valid=%0b instr=%08h pc=%08h addr=%03h, need 1/0/00000013/0/001",
                         k, FETCH_FAULT, IFID_VALID, IFID_INSTRUCTION, IFID_PC, ROM_ADDRESS);
            end
        end
        BRANCH_TAKEN = 1'b0; STALL = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checks++;
        if (FETCH_FAULT !== 1'b0 || ROM_ADDRESS !== 10'd0) begin
            errors++;
            $display("FAIL fault_reset: fault=%0b addr=%03h, need 0/000", FETCH_FAULT, ROM_ADDRESS);
        end
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        checks++;
        if (IFID_PC !== 32'd0 || IFID_VALID !== 1'b1 || IFID_INSTRUCTION !== rom[0]) begin
            errors++;
            $display("FAIL fault_restart: pc=%08h valid=%0b instr=%08h, need 00000000/1/%08h",
                     IFID_PC, IFID_VALID, IFID_INSTRUCTION, rom[0]);
        end
`else
        checks++;
        if (FETCH_FAULT !== 1'b0 || ROM_ADDRESS !== 10'd8) begin
            errors++;
            $display("FAIL misalign_forced: fault=%0b addr=%03h, need 0/008", FETCH_FAULT, ROM_ADDRESS);
        end
        tick();
        checks++;
        if (IFID_PC !== 32'h20 || IFID_INSTRUCTION !== rom[8] || IFID_VALID !== 1'b1) begin
            errors++;
            $display("FAIL misalign_fetch: pc=%08h instr=%08h valid=%0b, need 00000020/%08h/1",
                     IFID_PC, IFID_INSTRUCTION, IFID_VALID, rom[8]);
        end
`endif
    endtask

    task automatic test_async_reset();
        tick();
        checks++;
        if (IFID_VALID !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: valid=%0b, need 1", IFID_VALID);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (IFID_INSTRUCTION !== 32'h0000_0013 || IFID_PC !== 32'd0 || IFID_VALID !== 1'b0
            || ROM_ADDRESS !== 10'd0 || FETCH_FAULT !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: instr=%08h pc=%08h valid=%0b addr=%03h fault=%0b, need 00000013/0/0/000/0",
                     IFID_INSTRUCTION, IFID_PC, IFID_VALID, ROM_ADDRESS, FETCH_FAULT);
        end
        STALL = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h100;
        tick();
        checks++;
        if (IFID_VALID !== 1'b0 || ROM_ADDRESS !== 10'd0 || IFID_PC !== 32'd0) begin
            errors++;
            $display("FAIL reset_dominates: valid=%0b addr=%03h pc=%08h, need 0/000/0",
                     IFID_VALID, ROM_ADDRESS, IFID_PC);
        end
        STALL = 1'b0; BRANCH_TAKEN = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        checks++;
        if (IFID_PC !== 32'd0 || IFID_VALID !== 1'b1 || IFID_INSTRUCTION !== rom[0]) begin
            errors++;
            $display("FAIL first_after_reset: pc=%08h valid=%0b instr=%08h, need 00000000/1/%08h",
                     IFID_PC, IFID_VALID, IFID_INSTRUCTION, rom[0]);
        end
        tick();
        checks++;
        if (IFID_PC !== 32'd4 || IFID_INSTRUCTION !== rom[1]) begin
            errors++;
            $display("FAIL second_after_reset: pc=%08h instr=%08h, need 00000004/%08h",
                     IFID_PC, IFID_INSTRUCTION, rom[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 32'hC0DE_0000 | 32'(i * 7 + 3);
        end
        test_reset();
        test_sequential();
        test_stall();
        test_branch_over_stall();
        test_wrap();
        test_misalign();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the five-stage RV32I pipeline. Owns the program counter, drives the word address of the 1024×32 combinational instruction ROM, and registers the returned instruction plus its PC into the IF/ID pipeline register. Honours load-use stalls from the hazard unit and redirects from the branch/jump resolver. Squashed slots are filled with the canonical NOP.

## Interface
Parameters:
- RESET_VECTOR, 32'h00000000, byte address loaded into PC on reset.
- ROM_ADDR_WIDTH, 10, word-address width presented to the instruction ROM.

Ports:
- CLK, input, 1, single clock; all state updates on rising edge.
- RESET, input, 1, asynchronous, active-high reset.
- STALL, input, 1, hazard-unit hold request: PC and IF/ID hold.
- BRANCH_TAKEN, input, 1, redirect request from branch resolver.
- BRANCH_TARGET, input, 32, byte address to redirect to.
- ROM_ADDRESS, output, ROM_ADDR_WIDTH, = PC[ROM_ADDR_WIDTH+1:2], combinational from PC.
- ROM_DATA, input, 32, instruction word from ROM, valid same cycle as ROM_ADDRESS.
- IFID_INSTRUCTION, output, 32, registered instruction.
- IFID_PC, output, 32, registered PC of IFID_INSTRUCTION.
- IFID_VALID, output, 1, 1 = real instruction, 0 = bubble.
- FETCH_FAULT, output, 1, sticky misaligned-target flag (see Configuration).

## Operation
- States: RUN, FAULT. Reset enters RUN.
- Reset values: PC = RESET_VECTOR; IFID_INSTRUCTION = 32'h00000013; IFID_PC = 0; IFID_VALID = 0; FETCH_FAULT = 0.
- Per-cycle priority in RUN (highest first):
  - BRANCH_TAKEN: PC ← BRANCH_TARGET; IF/ID ← {NOP, PC=0, VALID=0}. Overrides STALL in the same cycle.
  - STALL: PC, IFID_INSTRUCTION, IFID_PC, IFID_VALID all hold.
  - Otherwise: IFID_INSTRUCTION ← ROM_DATA; IFID_PC ← PC; IFID_VALID ← 1; PC ← PC + 4.
- PC arithmetic modulo 2^32: 32'hFFFFFFFC + 4 = 0. No trap.
- PC bits above ROM_ADDR_WIDTH+1 ignored for ROM_ADDRESS; fetch aliases every 4 KiB.
- FAULT: PC holds; IF/ID ← NOP bubble every cycle; STALL and BRANCH_TAKEN ignored; exit only via RESET.
- RESET asserted mid-operation: all state returns to reset values immediately (asynchronous), regardless of STALL/BRANCH_TAKEN.

## Timing
- ROM_ADDRESS combinational from PC register; ROM_DATA sampled at the same edge that advances PC.
- Fetch latency: instruction at PC appears on IFID_INSTRUCTION one edge after PC is presented.
- First valid instruction: first edge after RESET deasserts → IFID_PC = RESET_VECTOR, IFID_VALID = 1 (if no STALL/branch).
- Redirect penalty: the edge that samples BRANCH_TAKEN produces one bubble; the target instruction is valid on the following edge.
- Stall of N cycles: IF/ID outputs constant for N edges; no instruction skipped or duplicated.

## Configuration
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined: BRANCH_TAKEN with BRANCH_TARGET[1:0] ≠ 2'b00 in RUN → state FAULT, FETCH_FAULT = 1 from that edge, PC not updated, IF/ID ← bubble.
- Undefined: BRANCH_TARGET[1:0] forced to 2'b00 on load; FAULT state absent; FETCH_FAULT tied 0.

## Structure
- Shared package: NOP encoding 32'h00000013, instruction width 32, default RESET_VECTOR, fetch state enum {RUN, FAULT}.
- One sub-module: program_counter (PC register, +4 incrementer, hold/load mux, target alignment). IF/ID register and state machine live in instruction_fetch.

## Test plan
- Reset release, ROM words 0..3 loaded, no stall → IFID_PC 0, 4, 8, 12 on consecutive edges, IFID_INSTRUCTION = ROM[0..3], IFID_VALID = 1.
- STALL high 2 cycles while IFID_PC = 8 → IFID_PC stays 8 for two edges, then 12; ROM_ADDRESS holds 3 during the stall.
- BRANCH_TAKEN with target 32'h20 and STALL simultaneously → next edge IFID_VALID = 0, IFID_INSTRUCTION = 32'h00000013; following edge IFID_PC = 32'h20.
- PC loaded via branch to 32'hFFFFFFFC → fetch at that PC (ROM_ADDRESS = 10'h3FF), next PC = 0, ROM_ADDRESS = 0.
- With FETCH_MISALIGN_CHECK_EN, branch to 32'h22 → FETCH_FAULT = 1, bubbles forever, PC unchanged; RESET clears to PC = RESET_VECTOR. Without the macro, the same branch fetches from 32'h20.
- RESET pulsed asynchronously between edges mid-stream → outputs return to reset values before next edge.
